// File: rtl/bus_gnrtr_n_rbtr.sv
// ---------------------------------------------------------------------------
// bus_gnrtr_n_rbtr
//
// Shared-bus generator and round-robin arbiter. Each of the `bits` buses
// connects `drvrs` first-word-fall-through driver FIFOs. Per bus, one packet
// at a time is popped from a pending driver. The destination ID in the
// packet's top byte selects where the packet is pushed:
//   - `broadcast`        : every driver except the source
//   - dest < drvrs       : that driver only (the source itself is allowed)
//   - anything else      : the packet is dropped
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   pndng   : [bits][drvrs]          driver FIFO non-empty flags
//   D_pop   : [bits][drvrs][pckg_sz] head word of each driver FIFO
//   pop     : [bits][drvrs]          one-cycle pop strobe to the source FIFO
//   push    : [bits][drvrs]          one-cycle push strobe to destination(s)
//   D_push  : [bits][drvrs][pckg_sz] packet presented to every destination;
//             it holds the last packet, so receivers must qualify it with push
//
// Every output comes straight from a flop. Each packet takes at least three
// cycles: IDLE (grant) -> POP (pop strobe) -> PUSH (push strobe).
// ---------------------------------------------------------------------------
module bus_gnrtr_n_rbtr #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    // Width of a driver index (at least one bit, so that drvrs == 1 works).
    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    for (genvar b = 0; b < bits; b++) begin : g_bus

        state_t             state_q, state_d;
        logic [IW-1:0]      rr_q, rr_d;       // first index to scan in IDLE
        logic [IW-1:0]      src_q, src_d;     // driver currently granted
        logic [pckg_sz-1:0] pkt_q, pkt_d;     // packet being delivered
        logic [drvrs-1:0]   pop_q, pop_d;
        logic [drvrs-1:0]   push_q, push_d;

        logic [pckg_sz-1:0] head;             // head word of granted FIFO
        logic [7:0]         dest;
        logic [IW-1:0]      idx;
        logic               found;

        assign head = D_pop[b][src_q];
        assign dest = head[pckg_sz-1 -: 8];

        // -------------------------------------------------------------------
        // Next-state and next-output logic
        // -------------------------------------------------------------------
        always_comb begin
            state_d = state_q;
            rr_d    = rr_q;
            src_d   = src_q;
            pkt_d   = pkt_q;
            pop_d   = '0;
            push_d  = '0;
            idx     = '0;
            found   = 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Cyclic scan starting at rr_q; the first pending driver
                    // found wins, which gives round-robin fairness.
                    for (int unsigned k = 0; k < 32'(drvrs); k++) begin
                        idx = IW'((32'(rr_q) + k) % 32'(drvrs));
                        if (!found && pndng[b][idx]) begin
                            found = 1'b1;
                            src_d = idx;
                        end
                    end
                    if (found) begin
                        state_d = POP;
                        // Registered, so the strobe is visible in POP.
                        pop_d   = drvrs'(1) << src_d;
                    end
                end

                POP: begin
                    // The head word is captured at the end of POP whether or
                    // not pndng is still high; push strobes are prepared now
                    // so that they appear, registered, during PUSH.
                    pkt_d   = head;
                    rr_d    = (src_q == IW'(drvrs - 1)) ? '0 : src_q + 1'b1;
                    state_d = PUSH;
                    if (dest == broadcast) begin
                        push_d = ~(drvrs'(1) << src_q);
                    end else if (int'(dest) < drvrs) begin
                        push_d = drvrs'(1) << dest;
                    end
                end

                PUSH: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // -------------------------------------------------------------------
        // State and output registers
        // -------------------------------------------------------------------
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                rr_q    <= '0;
                src_q   <= '0;
                pkt_q   <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                state_q <= state_d;
                rr_q    <= rr_d;
                src_q   <= src_d;
                pkt_q   <= pkt_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
            end
        end

        assign pop[b]    = pop_q;
        assign push[b]   = push_q;
        // The packet register feeds every lane directly: D_push stays a pure
        // flop output and naturally holds the last packet between transfers.
        assign D_push[b] = {drvrs{pkt_q}};

    end : g_bus

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// ---------------------------------------------------------------------------
// tb_bus_gnrtr_n_rbtr
//
// Bench for bus_gnrtr_n_rbtr with one bus of eight 16-bit drivers. Driver
// FIFOs are modelled as queues; each expected transfer (granted source,
// push mask, packet) is queued when its packets are loaded and is compared
// when the DUT pops and then pushes.
// ---------------------------------------------------------------------------
module tb_bus_gnrtr_n_rbtr;

    localparam int NB = 1;
    localparam int ND = 8;
    localparam int PW = 16;

    logic                          clk;
    logic                          reset;
    logic [NB-1:0][ND-1:0]         pndng;
    logic [NB-1:0][ND-1:0][PW-1:0] D_pop;
    logic [NB-1:0][ND-1:0]         pop;
    logic [NB-1:0][ND-1:0]         push;
    logic [NB-1:0][ND-1:0][PW-1:0] D_push;

    bus_gnrtr_n_rbtr #(
        .bits      (NB),
        .drvrs     (ND),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [7:0]  mask;
        logic [15:0] data;
    } exp_t;

    logic [15:0] fq [ND][$];
    exp_t        exp_q [$];
    exp_t        cur;
    logic        push_due;
    logic [7:0]  pop_seen;
    logic        inj_en;
    int          pops4;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] exp_mask(input int s, input logic [15:0] p);
        logic [7:0] d;
        d = p[15:8];
        if (d == 8'hFF)  return ~(8'(1) << s);
        else if (d < 8)  return 8'(1) << d;
        else             return 8'h00;
    endfunction

    function automatic logic [15:0] pkt_of(input int s, input int n);
        return {8'((s + 3) % 8), 8'(s * 16 + n)};
    endfunction

    task automatic expect_xfer(input int s, input logic [15:0] p);
        exp_t e;
        e.src  = s;
        e.mask = exp_mask(s, p);
        e.data = p;
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < ND; i++) begin
            pndng[0][i] = (fq[i].size() != 0);
            D_pop[0][i] = (fq[i].size() != 0) ? fq[i][0] : 16'h0000;
        end
    endtask

    task automatic monitor();
        pop_seen = pop[0];
        if (push_due) begin
            check("push_mask", 128'(push[0]), 128'(cur.mask));
            check("d_push", 128'(D_push), 128'({ND{cur.data}}));
            push_due = 1'b0;
        end else begin
            check("push_idle", 128'(push[0]), 128'(0));
        end
        if (pop[0] != 8'h00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 128'(pop[0]), 128'(0));
            end else begin
                cur = exp_q.pop_front();
                check("pop_grant", 128'(pop[0]), 128'(8'(1) << cur.src));
                push_due = 1'b1;
                if (inj_en && cur.src == 4) begin
                    pops4++;
                    if (pops4 == 2) fq[2].push_back(pkt_of(2, 0));
                end
            end
        end
    endtask

    // One clock: check outputs on the falling edge, then retire popped FIFO
    // heads and refresh the FIFO-side inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++)
            if (pop_seen[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || push_due) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'(0));
        repeat (2) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < ND; i++) fq[i].delete();
        exp_q.delete();
        push_due = 1'b0;
        pop_seen = 8'h00;
        drive_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int src_order [10];
        int ncnt [ND];
        int budget;

        checks   = 0;
        errors   = 0;
        push_due = 1'b0;
        pop_seen = 8'h00;
        inj_en   = 1'b0;
        pops4    = 0;
        reset    = 1'b0;
        pndng    = '0;
        D_pop    = '0;

        // Reset held with every driver pending: outputs stay at zero.
        for (int i = 0; i < ND; i++) begin
            fq[i].push_back(pkt_of(i, 0));
            expect_xfer(i, pkt_of(i, 0));
        end
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_pop", 128'(pop[0]), 128'(0));
            check("rst_push", 128'(push[0]), 128'(0));
            check("rst_dpush", 128'(D_push), 128'(0));
        end
        reset = 1'b1;
        // One rising edge after release, driver 0 must already be popped.
        step();
        check("first_pop", 128'(exp_q.size()), 128'(ND - 1));
        drain(60);

        // Unicast: driver 2 -> destination 5.
        fq[2].push_back(16'h05AB);
        exp_q.push_back('{src: 2, mask: 8'h20, data: 16'h05AB});
        drive_inputs();
        drain(20);

        // Broadcast from driver 3 reaches everyone but driver 3.
        fq[3].push_back(16'hFF12);
        exp_q.push_back('{src: 3, mask: 8'hF7, data: 16'hFF12});
        drive_inputs();
        drain(20);

        // Invalid destination 9: popped, never pushed.
        fq[0].push_back(16'h0912);
        exp_q.push_back('{src: 0, mask: 8'h00, data: 16'h0912});
        drive_inputs();
        drain(20);

        // Round-robin over drivers 1, 4, 6; driver 2 joins once rr_ptr is 5.
        // Scanning from 7 after driver 6 reaches 1 before 2.
        do_reset();
        src_order = '{1, 4, 6, 1, 4, 6, 1, 2, 4, 6};
        for (int i = 0; i < ND; i++) ncnt[i] = 0;
        for (int n = 0; n < 3; n++) begin
            fq[1].push_back(pkt_of(1, n));
            fq[4].push_back(pkt_of(4, n));
            fq[6].push_back(pkt_of(6, n));
        end
        for (int k = 0; k < 10; k++) begin
            expect_xfer(src_order[k], pkt_of(src_order[k], ncnt[src_order[k]]));
            ncnt[src_order[k]]++;
        end
        inj_en = 1'b1;
        pops4  = 0;
        drive_inputs();
        drain(80);
        inj_en = 1'b0;

        // All drivers busy with random packets: grants cycle 0..7.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < ND; i++) begin
                logic [15:0] p;
                logic [7:0]  d;
                case ($urandom_range(0, 2))
                    0:       d = 8'($urandom_range(0, 7));
                    1:       d = 8'hFF;
                    default: d = 8'($urandom_range(8, 254));
                endcase
                p = {d, 8'($urandom_range(0, 255))};
                fq[i].push_back(p);
                expect_xfer(i, p);
            end
        end
        drive_inputs();
        drain(200);

        // Reset during PUSH drops the strobe at once and restarts at rr_ptr 0.
        fq[5].push_back(16'h0312);
        drive_inputs();
        budget = 0;
        while (pop[0][5] !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("mt_pop_seen", 128'(pop[0]), 128'(8'h20));
        @(posedge clk);
        #1;
        void'(fq[5].pop_front());
        drive_inputs();
        check("mt_push_before", 128'(push[0]), 128'(8'h08));
        #2;
        reset = 1'b0;
        #1;
        check("mt_push_async", 128'(push[0]), 128'(0));
        check("mt_dpush_async", 128'(D_push), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        push_due = 1'b0;
        exp_q.delete();
        repeat (3) step();
        fq[7].push_back(16'h0155);
        fq[1].push_back(16'h0466);
        expect_xfer(1, 16'h0466);
        expect_xfer(7, 16'h0155);
        drive_inputs();
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
